// File: rtl/cursor_step_gen_pkg.sv
// Shared definitions for the cursor step front end.
// Holds the direction encoding, FSM state encoding, default timing constants,
// the fixed-priority arbiter and the direction-to-strobe mapping.
package cursor_step_gen_pkg;

    typedef enum logic [2:0] {
        DIR_NONE  = 3'd0,
        DIR_UP    = 3'd1,
        DIR_DOWN  = 3'd2,
        DIR_LEFT  = 3'd3,
        DIR_RIGHT = 3'd4
    } dir_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HOLD,
        ST_REPEAT
    } state_e;

    localparam int unsigned DEF_DEBOUNCE_CYCLES = 650000;
    localparam int unsigned DEF_HOLD_CYCLES     = 19500000;
    localparam int unsigned DEF_REPEAT_CYCLES   = 1300000;
    localparam int unsigned DEF_CNT_W           = 25;

    // Priority down > up > left > right, identical to move_cursor.
    function automatic dir_e arbitrate(input logic up, input logic down,
                                       input logic left, input logic right);
        if (down)       return DIR_DOWN;
        else if (up)    return DIR_UP;
        else if (left)  return DIR_LEFT;
        else if (right) return DIR_RIGHT;
        else            return DIR_NONE;
    endfunction

    // Strobe vector ordering is {up, down, left, right}.
    function automatic logic [3:0] dir_to_strobe(input dir_e dir);
        case (dir)
            DIR_UP:    return 4'b1000;
            DIR_DOWN:  return 4'b0100;
            DIR_LEFT:  return 4'b0010;
            DIR_RIGHT: return 4'b0001;
            default:   return 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/cursor_step_gen_debounce_sync.sv
// Two-flop synchronizer followed by a stable-sample debouncer.
// Ports:
//   clk      in   system clock
//   reset    in   synchronous, active-high reset
//   i_raw    in   raw asynchronous, bouncy input
//   o_level  out  debounced level
// The level flips only after DEBOUNCE_CYCLES consecutive synced samples that
// differ from it; any agreeing sample restarts the count.
module cursor_step_gen_debounce_sync
    import cursor_step_gen_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned CNT_W           = DEF_CNT_W
) (
    input  logic clk,
    input  logic reset,
    input  logic i_raw,
    output logic o_level
);

    localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            if (r_sync2 != r_level) begin
                if (r_cnt == LP_LAST) begin
                    r_level <= r_sync2;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_level = r_level;

endmodule

// File: rtl/cursor_step_gen.sv
// Arrow-button front end for the manual corner-adjust UI.
// Ports:
//   clk, reset                        clock, synchronous active-high reset
//   btn_{up,down,left,right}_raw      raw bouncy buttons (active high)
//   override_raw                      raw bouncy override switch
//   up, down, left, right             single-cycle step strobes
//   override                          debounced override level
// One strobe on press, a second after HOLD_CYCLES, then one every REPEAT_CYCLES
// while the same arbitrated direction stays held and override is on.
module cursor_step_gen
    import cursor_step_gen_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned HOLD_CYCLES     = DEF_HOLD_CYCLES,
    parameter int unsigned REPEAT_CYCLES   = DEF_REPEAT_CYCLES,
    parameter int unsigned CNT_W           = DEF_CNT_W
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_up_raw,
    input  logic btn_down_raw,
    input  logic btn_left_raw,
    input  logic btn_right_raw,
    input  logic override_raw,
    output logic up,
    output logic down,
    output logic left,
    output logic right,
    output logic override
);

    localparam logic [CNT_W-1:0] LP_HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] LP_REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

    logic w_up_db, w_down_db, w_left_db, w_right_db, w_ovr_db;
    dir_e w_sel;

    state_e           r_state, w_nxt_state;
    dir_e             r_dir,   w_nxt_dir;
    logic [CNT_W-1:0] r_cnt,   w_nxt_cnt;
    logic [3:0]       r_strobe, w_nxt_strobe;

    cursor_step_gen_debounce_sync #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_up (
        .clk(clk), .reset(reset), .i_raw(btn_up_raw), .o_level(w_up_db));
    cursor_step_gen_debounce_sync #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_down (
        .clk(clk), .reset(reset), .i_raw(btn_down_raw), .o_level(w_down_db));
    cursor_step_gen_debounce_sync #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_left (
        .clk(clk), .reset(reset), .i_raw(btn_left_raw), .o_level(w_left_db));
    cursor_step_gen_debounce_sync #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_right (
        .clk(clk), .reset(reset), .i_raw(btn_right_raw), .o_level(w_right_db));
    cursor_step_gen_debounce_sync #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_ovr (
        .clk(clk), .reset(reset), .i_raw(override_raw), .o_level(w_ovr_db));

    assign w_sel = arbitrate(w_up_db, w_down_db, w_left_db, w_right_db);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_dir    <= DIR_NONE;
            r_cnt    <= '0;
            r_strobe <= '0;
        end else begin
            r_state  <= w_nxt_state;
            r_dir    <= w_nxt_dir;
            r_cnt    <= w_nxt_cnt;
            r_strobe <= w_nxt_strobe;
        end
    end

    always_comb begin
        w_nxt_state  = r_state;
        w_nxt_dir    = r_dir;
        w_nxt_cnt    = r_cnt;
        w_nxt_strobe = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_ovr_db && (w_sel != DIR_NONE)) begin
                    w_nxt_strobe = dir_to_strobe(w_sel);
                    w_nxt_dir    = w_sel;
                    w_nxt_cnt    = '0;
                    w_nxt_state  = ST_HOLD;
                end
            end
            ST_HOLD, ST_REPEAT: begin
                // A changed selection is never pulsed here; it is picked up
                // from IDLE on the following cycle.
                if (!w_ovr_db || (w_sel != r_dir)) begin
                    w_nxt_state = ST_IDLE;
                    w_nxt_dir   = DIR_NONE;
                    w_nxt_cnt   = '0;
                end else if (r_cnt == ((r_state == ST_HOLD) ? LP_HOLD_LAST : LP_REPEAT_LAST)) begin
                    w_nxt_strobe = dir_to_strobe(r_dir);
                    w_nxt_cnt    = '0;
                    w_nxt_state  = ST_REPEAT;
                end else begin
                    w_nxt_cnt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_nxt_state = ST_IDLE;
                w_nxt_dir   = DIR_NONE;
                w_nxt_cnt   = '0;
            end
        endcase
    end

    // Gating by the live override level keeps a strobe registered on the
    // cycle override drops from ever appearing while override reads 0.
    assign up       = r_strobe[3] & w_ovr_db;
    assign down     = r_strobe[2] & w_ovr_db;
    assign left     = r_strobe[1] & w_ovr_db;
    assign right    = r_strobe[0] & w_ovr_db;
    assign override = w_ovr_db;

endmodule

// File: tb/tb_cursor_step_gen.sv
module tb_cursor_step_gen;

    logic clk = 1'b0;
    logic reset;
    logic btn_up_raw, btn_down_raw, btn_left_raw, btn_right_raw, override_raw;
    logic up, down, left, right, override;

    typedef struct {
        int unsigned cyc;
        logic [3:0]  vec;
    } ev_t;

    ev_t         sb[$];
    int unsigned cyc    = 0;
    int unsigned errors = 0;
    int unsigned checks = 0;
    int unsigned n_left = 0;
    int unsigned n_right = 0;

    localparam logic [3:0] V_UP    = 4'b1000;
    localparam logic [3:0] V_DOWN  = 4'b0100;
    localparam logic [3:0] V_RIGHT = 4'b0001;

    cursor_step_gen #(
        .DEBOUNCE_CYCLES(4),
        .HOLD_CYCLES(10),
        .REPEAT_CYCLES(3),
        .CNT_W(8)
    ) dut (
        .clk(clk), .reset(reset),
        .btn_up_raw(btn_up_raw), .btn_down_raw(btn_down_raw),
        .btn_left_raw(btn_left_raw), .btn_right_raw(btn_right_raw),
        .override_raw(override_raw),
        .up(up), .down(down), .left(left), .right(right), .override(override)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic push(input int unsigned c, input logic [3:0] v);
        ev_t e;
        e.cyc = c;
        e.vec = v;
        sb.push_back(e);
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Strobe monitor: every asserted strobe must match the oldest expected event.
    always @(negedge clk) begin
        logic [3:0] w;
        ev_t        e;
        w = {up, down, left, right};
        if (left)  n_left++;
        if (right) n_right++;
        if (w != 4'b0000) begin
            chk("strobe_onehot", 32'($onehot(w)), 32'd1);
            chk("strobe_while_override", 32'(override), 32'd1);
            if (sb.size() == 0) begin
                chk("unexpected_strobe", 32'(w), 32'd0);
            end else begin
                e = sb.pop_front();
                chk("strobe_cycle", cyc, e.cyc);
                chk("strobe_dir", 32'(w), 32'(e.vec));
            end
        end
    end

    initial begin
        int unsigned t;
        reset = 1'b1;
        btn_up_raw = 1'b0; btn_down_raw = 1'b0; btn_left_raw = 1'b0; btn_right_raw = 1'b0;
        override_raw = 1'b1;

        // Reset state
        tick(3);
        chk("reset_outputs", 32'({up, down, left, right, override}), 32'd0);
        reset = 1'b0;
        tick(12);
        chk("override_after_reset", 32'(override), 32'd1);

        // 1: up held 40 cycles, then released
        t = cyc;
        btn_up_raw = 1'b1;
        push(t + 7, V_UP); push(t + 17, V_UP);
        for (int unsigned k = 20; k <= 44; k += 3) push(t + k, V_UP);
        tick(40);
        btn_up_raw = 1'b0;
        tick(20);
        chk("t1_all_strobes_seen", sb.size(), 32'd0);

        // 2: left chatter shorter than debounce window
        for (int unsigned k = 0; k < 16; k++) begin
            btn_left_raw = ~btn_left_raw;
            tick(2);
        end
        tick(10);
        chk("t2_no_left", n_left, 32'd0);
        chk("t2_queue", sb.size(), 32'd0);

        // 3: down pressed while up is in HOLD
        t = cyc;
        btn_up_raw = 1'b1;
        push(t + 7, V_UP);
        tick(10);
        btn_down_raw = 1'b1;
        push(t + 18, V_DOWN); push(t + 28, V_DOWN); push(t + 31, V_DOWN); push(t + 34, V_DOWN);
        tick(20);
        btn_up_raw = 1'b0; btn_down_raw = 1'b0;
        tick(20);
        chk("t3_all_strobes_seen", sb.size(), 32'd0);

        // 4: all four together, then hand off from down to up
        t = cyc;
        btn_up_raw = 1'b1; btn_down_raw = 1'b1; btn_left_raw = 1'b1; btn_right_raw = 1'b1;
        push(t + 7, V_DOWN); push(t + 17, V_DOWN); push(t + 20, V_DOWN);
        push(t + 23, V_DOWN); push(t + 26, V_DOWN); push(t + 29, V_DOWN);
        push(t + 32, V_UP); push(t + 42, V_UP); push(t + 45, V_UP); push(t + 48, V_UP);
        tick(24);
        btn_down_raw = 1'b0;
        tick(19);
        btn_up_raw = 1'b0; btn_left_raw = 1'b0; btn_right_raw = 1'b0;
        tick(20);
        chk("t4_all_strobes_seen", sb.size(), 32'd0);
        chk("t4_left_never", n_left, 32'd0);

        // 5: override off blocks right; re-enabling releases it
        override_raw = 1'b0;
        tick(5);
        chk("t5_override_still_high", 32'(override), 32'd1);
        tick(1);
        chk("t5_override_low", 32'(override), 32'd0);
        tick(4);
        btn_right_raw = 1'b1;
        tick(20);
        chk("t5_no_right_while_off", n_right, 32'd0);
        t = cyc;
        override_raw = 1'b1;
        push(t + 7, V_RIGHT); push(t + 17, V_RIGHT); push(t + 20, V_RIGHT);
        tick(5);
        chk("t5_override_not_yet", 32'(override), 32'd0);
        tick(1);
        chk("t5_override_high", 32'(override), 32'd1);

        // 6: reset pulse during REPEAT with right still held
        tick(15);
        reset = 1'b1;
        tick(1);
        chk("t6_reset_outputs", 32'({up, down, left, right, override}), 32'd0);
        reset = 1'b0;
        push(t + 29, V_RIGHT); push(t + 39, V_RIGHT); push(t + 42, V_RIGHT); push(t + 45, V_RIGHT);
        tick(5);
        chk("t6_override_not_yet", 32'(override), 32'd0);
        tick(1);
        chk("t6_override_high", 32'(override), 32'd1);
        tick(12);
        btn_right_raw = 1'b0;
        tick(20);
        chk("t6_all_strobes_seen", sb.size(), 32'd0);
        chk("t6_right_count", n_right, 32'd7);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
